// File: rtl/rr_mux_reg.sv
// N_CH:1 round-robin stream mux feeding a one-entry output register; 1-cycle latency, full rate when out_ready=1.
// Optional macro RR_MUX_REG_CH_ID_EN adds out_ch, the source channel registered alongside each word.
module rr_mux_reg #(
   parameter int N_CH  = 4,
   parameter int W     = 4,
   parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_CH-1:0]     in_valid,
   input  logic [N_CH*W-1:0]   in_data,
   output logic [N_CH-1:0]     in_ready,
   output logic                out_valid,
   output logic [W-1:0]        out_data,
`ifdef RR_MUX_REG_CH_ID_EN
   output logic [SEL_W-1:0]    out_ch,
`endif
   input  logic                out_ready
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W-1:0] ptr_next;
   logic [N_CH-1:0]  at_or_after;
   logic [N_CH-1:0]  req_hi;
   logic [N_CH-1:0]  req_pick;
   logic [N_CH-1:0]  grant_oh;
   logic [W-1:0]     grant_data;
   logic             load;
   logic             xfer;

   assign load = !out_valid || out_ready;

   for (genvar i = 0; i < N_CH; i++) begin : g_mask
      assign at_or_after[i] = (SEL_W'(i) >= ptr);
   end

   // Requests at or above ptr take priority; otherwise wrap to the lowest requester.
   assign req_hi   = in_valid & at_or_after;
   assign req_pick = (|req_hi) ? req_hi : in_valid;
   assign grant_oh = req_pick & (~req_pick + N_CH'(1));

   assign in_ready = (load && !rst) ? grant_oh : '0;
   assign xfer     = |(in_valid & in_ready);

   always_comb begin
      grant_idx  = '0;
      grant_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (grant_oh[k]) begin
            grant_idx  = grant_idx | SEL_W'(k);
            grant_data = grant_data | in_data[k*W +: W];
         end
      end
      ptr_next = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         ptr       <= '0;
`ifdef RR_MUX_REG_CH_ID_EN
         out_ch    <= '0;
`endif
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         ptr       <= ptr_next;
`ifdef RR_MUX_REG_CH_ID_EN
         out_ch    <= grant_idx;
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
